// File: rtl/reg_arb_pkg.sv
// Shared types and defaults for the register-bus arbiter.
package reg_arb_pkg;

  localparam int DEF_ADDR_WIDTH     = 16;
  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_TIMEOUT_CYCLES = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } arb_state_e;

  typedef logic req_id_t;

  localparam req_id_t REQ_SPI = 1'b0;
  localparam req_id_t REQ_LOC = 1'b1;

  // Width of a counter that must reach cycles-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/reg_access_arbiter_if.sv
// Shared control register bus: arbiter drives strobes/address/data, register banks return read data.
interface reg_access_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);

  logic                  o_bus_wr_en;
  logic                  o_bus_rd_en;
  logic [ADDR_WIDTH-1:0] ov_bus_addr;
  logic [DATA_WIDTH-1:0] ov_bus_wr_data;
  logic                  i_bus_rd_valid;
  logic [DATA_WIDTH-1:0] iv_bus_rd_data;

  modport master (
    output o_bus_wr_en,
    output o_bus_rd_en,
    output ov_bus_addr,
    output ov_bus_wr_data,
    input  i_bus_rd_valid,
    input  iv_bus_rd_data
  );

  modport slave (
    input  o_bus_wr_en,
    input  o_bus_rd_en,
    input  ov_bus_addr,
    input  ov_bus_wr_data,
    output i_bus_rd_valid,
    output iv_bus_rd_data
  );

endinterface

// File: rtl/reg_arb_rr2.sv
// Two-input round-robin pick; purely combinational, last grant is held by the parent.
module reg_arb_rr2
  import reg_arb_pkg::*;
(
  input  logic    i_req_spi,
  input  logic    i_req_loc,
  input  req_id_t i_last_grant,
  input  logic    i_en,
  output req_id_t o_grant,
  output logic    o_any_req
);

  always_comb begin
    o_grant = REQ_SPI;
    if (i_req_spi && i_req_loc) begin
      o_grant = (i_last_grant == REQ_SPI) ? REQ_LOC : REQ_SPI;
    end else if (i_req_loc) begin
      o_grant = REQ_LOC;
    end
  end

  assign o_any_req = i_en && (i_req_spi || i_req_loc);

endmodule

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter sharing the camera control register bus between the SPI host port and the init sequencer.
// Define REG_ARB_TIMEOUT_EN to enable the read timeout counter and the err outputs.
//
// state   | meaning
// IDLE    | no access in flight; arbitrate and latch the winner's request
// ISSUE   | one-cycle write or read strobe on the bus
// WAIT_RD | waiting for read-valid from the addressed register block
// RESP    | one-cycle ack to the granted requester
module reg_access_arbiter
  import reg_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk_reg,
  input  logic                  reset_reg,

  input  logic                  i_spi_req,
  input  logic                  i_spi_wr,
  input  logic [ADDR_WIDTH-1:0] iv_spi_addr,
  input  logic [DATA_WIDTH-1:0] iv_spi_wr_data,
  output logic                  o_spi_ack,
  output logic [DATA_WIDTH-1:0] ov_spi_rd_data,
  output logic                  o_spi_err,

  input  logic                  i_loc_req,
  input  logic                  i_loc_wr,
  input  logic [ADDR_WIDTH-1:0] iv_loc_addr,
  input  logic [DATA_WIDTH-1:0] iv_loc_wr_data,
  output logic                  o_loc_ack,
  output logic [DATA_WIDTH-1:0] ov_loc_rd_data,
  output logic                  o_loc_err,

  reg_access_arbiter_if.master  bus,

  output logic                  o_busy,
  output logic                  o_grant_spi
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("reg_access_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_e            state_q, state_d;
  logic                  grant_spi_q, grant_spi_d;
  logic                  cur_wr_q, cur_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  spi_ack_q, spi_ack_d;
  logic                  loc_ack_q, loc_ack_d;
  logic [DATA_WIDTH-1:0] spi_rd_q, spi_rd_d;
  logic [DATA_WIDTH-1:0] loc_rd_q, loc_rd_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] resp_data;
  req_id_t               pick_id;
  req_id_t               last_grant;
  logic                  any_req;

`ifdef REG_ARB_TIMEOUT_EN
  localparam int              CNT_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             spi_err_q, spi_err_d;
  logic             loc_err_q, loc_err_d;
  logic             resp_err;
`endif

  // The grant flag doubles as the round-robin history and the id of the access in flight.
  assign last_grant = grant_spi_q ? REQ_SPI : REQ_LOC;

  reg_arb_rr2 u_rr2 (
    .i_req_spi    (i_spi_req),
    .i_req_loc    (i_loc_req),
    .i_last_grant (last_grant),
    .i_en         (state_q == IDLE),
    .o_grant      (pick_id),
    .o_any_req    (any_req)
  );

  always_comb begin
    state_d     = state_q;
    grant_spi_d = grant_spi_q;
    cur_wr_d    = cur_wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    spi_ack_d   = 1'b0;
    loc_ack_d   = 1'b0;
    spi_rd_d    = spi_rd_q;
    loc_rd_d    = loc_rd_q;
    resp_data   = '0;
`ifdef REG_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    spi_err_d   = spi_err_q;
    loc_err_d   = loc_err_q;
    resp_err    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d     = ISSUE;
          grant_spi_d = (pick_id == REQ_SPI);
          if (pick_id == REQ_SPI) begin
            cur_wr_d = i_spi_wr;
            addr_d   = iv_spi_addr;
            wdata_d  = iv_spi_wr_data;
          end else begin
            cur_wr_d = i_loc_wr;
            addr_d   = iv_loc_addr;
            wdata_d  = iv_loc_wr_data;
          end
          wr_en_d = cur_wr_d;
          rd_en_d = !cur_wr_d;
        end
      end

      ISSUE: begin
        if (cur_wr_q) begin
          state_d = RESP;
        end else begin
          state_d = WAIT_RD;
`ifdef REG_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      WAIT_RD: begin
        // A valid on the last allowed cycle still wins over the timeout.
        if (bus.i_bus_rd_valid) begin
          state_d   = RESP;
          resp_data = bus.iv_bus_rd_data;
`ifdef REG_ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RESP;
          resp_data = '0;
          resp_err  = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == RESP) begin
      if (grant_spi_q) begin
        spi_ack_d = 1'b1;
        if (!cur_wr_q) spi_rd_d = resp_data;
      end else begin
        loc_ack_d = 1'b1;
        if (!cur_wr_q) loc_rd_d = resp_data;
      end
`ifdef REG_ARB_TIMEOUT_EN
      if (grant_spi_q) spi_err_d = resp_err;
      else             loc_err_d = resp_err;
`endif
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_reg or posedge reset_reg) begin
    if (reset_reg) begin
      state_q     <= IDLE;
      grant_spi_q <= 1'b0;
      cur_wr_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      spi_ack_q   <= 1'b0;
      loc_ack_q   <= 1'b0;
      spi_rd_q    <= '0;
      loc_rd_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_spi_q <= grant_spi_d;
      cur_wr_q    <= cur_wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      spi_ack_q   <= spi_ack_d;
      loc_ack_q   <= loc_ack_d;
      spi_rd_q    <= spi_rd_d;
      loc_rd_q    <= loc_rd_d;
      busy_q      <= busy_d;
    end
  end

`ifdef REG_ARB_TIMEOUT_EN
  always_ff @(posedge clk_reg or posedge reset_reg) begin
    if (reset_reg) begin
      cnt_q     <= '0;
      spi_err_q <= 1'b0;
      loc_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      spi_err_q <= spi_err_d;
      loc_err_q <= loc_err_d;
    end
  end

  assign o_spi_err = spi_err_q;
  assign o_loc_err = loc_err_q;
`else
  assign o_spi_err = 1'b0;
  assign o_loc_err = 1'b0;
`endif

  assign o_spi_ack          = spi_ack_q;
  assign o_loc_ack          = loc_ack_q;
  assign ov_spi_rd_data     = spi_rd_q;
  assign ov_loc_rd_data     = loc_rd_q;
  assign o_busy             = busy_q;
  assign o_grant_spi        = grant_spi_q;
  assign bus.o_bus_wr_en    = wr_en_q;
  assign bus.o_bus_rd_en    = rd_en_q;
  assign bus.ov_bus_addr    = addr_q;
  assign bus.ov_bus_wr_data = wdata_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter: scheduled requests, scoreboarded strobes and acks.
`timescale 1ns/1ps
module tb_reg_access_arbiter;
  import reg_arb_pkg::*;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int TMO = 15;

  logic          clk_reg   = 1'b0;
  logic          reset_reg = 1'b1;
  logic          i_spi_req = 1'b0, i_loc_req = 1'b0;
  logic          i_spi_wr  = 1'b0, i_loc_wr  = 1'b0;
  logic [AW-1:0] iv_spi_addr = '0, iv_loc_addr = '0;
  logic [DW-1:0] iv_spi_wr_data = '0, iv_loc_wr_data = '0;
  logic          o_spi_ack, o_loc_ack, o_spi_err, o_loc_err, o_busy, o_grant_spi;
  logic [DW-1:0] ov_spi_rd_data, ov_loc_rd_data;

  reg_access_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  reg_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_reg        (clk_reg),
    .reset_reg      (reset_reg),
    .i_spi_req      (i_spi_req),
    .i_spi_wr       (i_spi_wr),
    .iv_spi_addr    (iv_spi_addr),
    .iv_spi_wr_data (iv_spi_wr_data),
    .o_spi_ack      (o_spi_ack),
    .ov_spi_rd_data (ov_spi_rd_data),
    .o_spi_err      (o_spi_err),
    .i_loc_req      (i_loc_req),
    .i_loc_wr       (i_loc_wr),
    .iv_loc_addr    (iv_loc_addr),
    .iv_loc_wr_data (iv_loc_wr_data),
    .o_loc_ack      (o_loc_ack),
    .ov_loc_rd_data (ov_loc_rd_data),
    .o_loc_err      (o_loc_err),
    .bus            (bus),
    .o_busy         (o_busy),
    .o_grant_spi    (o_grant_spi)
  );

  always #5 clk_reg = ~clk_reg;

  int cyc = 0;
  always @(posedge clk_reg) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gspi;
  } stb_exp_t;

  typedef struct {
    int            cyc;
    logic          is_spi;
    logic [DW-1:0] spi_rd;
    logic [DW-1:0] loc_rd;
    logic          err;
  } ack_exp_t;

  stb_exp_t stb_q[$];
  ack_exp_t ack_q[$];
  stb_exp_t ms;
  ack_exp_t ma;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] m_spi_rd = '0;
  logic [DW-1:0] m_loc_rd = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic exp_stb(input int c, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic g);
    stb_exp_t e;
    e.cyc = c; e.wr = wr; e.addr = a; e.wdata = d; e.gspi = g;
    stb_q.push_back(e);
  endtask

  task automatic exp_ack(input int c, input logic is_spi, input logic err);
    ack_exp_t e;
    e.cyc = c; e.is_spi = is_spi; e.spi_rd = m_spi_rd; e.loc_rd = m_loc_rd; e.err = err;
    ack_q.push_back(e);
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk_reg);
      #1;
    end
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_ctl"}, 64'({o_spi_ack, o_loc_ack, o_spi_err, o_loc_err, o_busy, o_grant_spi,
                            bus.o_bus_wr_en, bus.o_bus_rd_en}), 64'(0));
    chk({tag, "_rd"}, 64'({ov_spi_rd_data, ov_loc_rd_data}), 64'(0));
    chk({tag, "_bus"}, 64'({bus.ov_bus_addr, bus.ov_bus_wr_data}), 64'(0));
  endtask

  // Scoreboard: every strobe and ack the DUT produces must match the next queued expectation.
  always @(negedge clk_reg) begin
    if (!reset_reg) begin
      if (bus.o_bus_wr_en || bus.o_bus_rd_en) begin
        chk("strobe_overlap", 64'(bus.o_bus_wr_en & bus.o_bus_rd_en), 64'(0));
        if (stb_q.size() == 0) begin
          chk("strobe_unexpected", 64'(stb_q.size()), 64'(1));
        end else begin
          ms = stb_q.pop_front();
          chk("stb_cycle", 64'(cyc), 64'(ms.cyc));
          chk("stb_wr", 64'(bus.o_bus_wr_en), 64'(ms.wr));
          chk("stb_addr", 64'(bus.ov_bus_addr), 64'(ms.addr));
          chk("stb_wdata", 64'(bus.ov_bus_wr_data), 64'(ms.wdata));
          chk("stb_grant_spi", 64'(o_grant_spi), 64'(ms.gspi));
        end
      end
      if (o_spi_ack || o_loc_ack) begin
        chk("ack_overlap", 64'(o_spi_ack & o_loc_ack), 64'(0));
        if (ack_q.size() == 0) begin
          chk("ack_unexpected", 64'(ack_q.size()), 64'(1));
        end else begin
          ma = ack_q.pop_front();
          chk("ack_cycle", 64'(cyc), 64'(ma.cyc));
          chk("ack_port_spi", 64'(o_spi_ack), 64'(ma.is_spi));
          chk("ack_spi_rd", 64'(ov_spi_rd_data), 64'(ma.spi_rd));
          chk("ack_loc_rd", 64'(ov_loc_rd_data), 64'(ma.loc_rd));
          chk("ack_err", 64'(ma.is_spi ? o_spi_err : o_loc_err), 64'(ma.err));
        end
      end
    end
  end

  initial begin
    int t;
    bus.i_bus_rd_valid = 1'b0;
    bus.iv_bus_rd_data = '0;

    repeat (3) @(posedge clk_reg);
    @(negedge clk_reg);
    rst_chk("reset");
    goto(4);
    reset_reg = 1'b0;

    // Tie after reset, then both keep re-requesting: SPI, LOC, SPI, LOC.
    t = 6;
    goto(t);
    i_spi_req = 1'b1; i_spi_wr = 1'b1; iv_spi_addr = 16'h0100; iv_spi_wr_data = 16'h0001;
    i_loc_req = 1'b1; i_loc_wr = 1'b1; iv_loc_addr = 16'h0040; iv_loc_wr_data = 16'h1111;
    exp_stb(t + 1,  1'b1, 16'h0100, 16'h0001, 1'b1); exp_ack(t + 2,  1'b1, 1'b0);
    exp_stb(t + 4,  1'b1, 16'h0041, 16'h2222, 1'b0); exp_ack(t + 5,  1'b0, 1'b0);
    exp_stb(t + 7,  1'b1, 16'h0101, 16'h0003, 1'b1); exp_ack(t + 8,  1'b1, 1'b0);
    exp_stb(t + 10, 1'b1, 16'h0042, 16'h4444, 1'b0); exp_ack(t + 11, 1'b0, 1'b0);
    goto(t + 1);
    iv_loc_addr = 16'h0041; iv_loc_wr_data = 16'h2222;
    @(negedge clk_reg);
    chk("busy_in_issue", 64'(o_busy), 64'(1));
    goto(t + 3);
    iv_spi_addr = 16'h0101; iv_spi_wr_data = 16'h0003;
    goto(t + 6);
    iv_loc_addr = 16'h0042; iv_loc_wr_data = 16'h4444;
    goto(t + 9);
    i_spi_req = 1'b0;
    goto(t + 12);
    i_loc_req = 1'b0;
    @(negedge clk_reg);
    chk("idle_busy", 64'(o_busy), 64'(0));
    chk("idle_grant_spi", 64'(o_grant_spi), 64'(0));

    // SPI write; a stray rd_valid during ISSUE must be ignored.
    t = 20;
    goto(t);
    i_spi_req = 1'b1; i_spi_wr = 1'b1; iv_spi_addr = 16'h0010; iv_spi_wr_data = 16'hA5A5;
    exp_stb(t + 1, 1'b1, 16'h0010, 16'hA5A5, 1'b1); exp_ack(t + 2, 1'b1, 1'b0);
    goto(t + 1);
    bus.i_bus_rd_valid = 1'b1; bus.iv_bus_rd_data = 16'hDEAD;
    goto(t + 2);
    bus.i_bus_rd_valid = 1'b0;
    goto(t + 3);
    i_spi_req = 1'b0;

    // SPI read with rd_valid at the earliest cycle.
    t = 26;
    goto(t);
    i_spi_req = 1'b1; i_spi_wr = 1'b0; iv_spi_addr = 16'h0030; iv_spi_wr_data = 16'h0000;
    exp_stb(t + 1, 1'b0, 16'h0030, 16'h0000, 1'b1);
    m_spi_rd = 16'hBEEF;
    exp_ack(t + 3, 1'b1, 1'b0);
    goto(t + 2);
    bus.i_bus_rd_valid = 1'b1; bus.iv_bus_rd_data = 16'hBEEF;
    goto(t + 3);
    bus.i_bus_rd_valid = 1'b0;
    goto(t + 4);
    i_spi_req = 1'b0;

    // LOC read, valid three cycles after rd_en; junk valid during ISSUE.
    t = 32;
    goto(t);
    i_loc_req = 1'b1; i_loc_wr = 1'b0; iv_loc_addr = 16'h0020; iv_loc_wr_data = 16'h0000;
    exp_stb(t + 1, 1'b0, 16'h0020, 16'h0000, 1'b0);
    m_loc_rd = 16'h1234;
    exp_ack(t + 5, 1'b0, 1'b0);
    goto(t + 1);
    bus.i_bus_rd_valid = 1'b1; bus.iv_bus_rd_data = 16'h0BAD;
    goto(t + 2);
    bus.i_bus_rd_valid = 1'b0;
    goto(t + 4);
    bus.i_bus_rd_valid = 1'b1; bus.iv_bus_rd_data = 16'h1234;
    goto(t + 5);
    bus.i_bus_rd_valid = 1'b0;
    goto(t + 6);
    i_loc_req = 1'b0;

    // SPI write leaves the SPI read data untouched.
    t = 40;
    goto(t);
    i_spi_req = 1'b1; i_spi_wr = 1'b1; iv_spi_addr = 16'h0011; iv_spi_wr_data = 16'h5555;
    exp_stb(t + 1, 1'b1, 16'h0011, 16'h5555, 1'b1); exp_ack(t + 2, 1'b1, 1'b0);
    goto(t + 3);
    i_spi_req = 1'b0;

    t = 45;
    goto(t);
`ifdef REG_ARB_TIMEOUT_EN
    i_loc_req = 1'b1; i_loc_wr = 1'b0; iv_loc_addr = 16'h0050; iv_loc_wr_data = 16'h0000;
    exp_stb(t + 1, 1'b0, 16'h0050, 16'h0000, 1'b0);
    m_loc_rd = 16'h0000;
    exp_ack(t + 2 + TMO, 1'b0, 1'b1);
    goto(t + 3 + TMO);
    i_loc_req = 1'b0;

    t = 66;
    goto(t);
    i_spi_req = 1'b1; i_spi_wr = 1'b0; iv_spi_addr = 16'h0060; iv_spi_wr_data = 16'h0000;
    exp_stb(t + 1, 1'b0, 16'h0060, 16'h0000, 1'b1);
    m_spi_rd = 16'hCAFE;
    exp_ack(t + 2 + TMO, 1'b1, 1'b0);
    goto(t + 1 + TMO);
    bus.i_bus_rd_valid = 1'b1; bus.iv_bus_rd_data = 16'hCAFE;
    goto(t + 2 + TMO);
    bus.i_bus_rd_valid = 1'b0;
    goto(t + 3 + TMO);
    i_spi_req = 1'b0;

    t = 86;
    goto(t);
    i_loc_req = 1'b1; i_loc_wr = 1'b1; iv_loc_addr = 16'h0070; iv_loc_wr_data = 16'h9999;
    exp_stb(t + 1, 1'b1, 16'h0070, 16'h9999, 1'b0); exp_ack(t + 2, 1'b0, 1'b0);
    goto(t + 3);
    i_loc_req = 1'b0;
`else
    i_loc_req = 1'b1; i_loc_wr = 1'b0; iv_loc_addr = 16'h0050; iv_loc_wr_data = 16'h0000;
    exp_stb(t + 1, 1'b0, 16'h0050, 16'h0000, 1'b0);
    m_loc_rd = 16'h5A5A;
    exp_ack(t + 31, 1'b0, 1'b0);
    goto(t + 20);
    @(negedge clk_reg);
    chk("long_wait_busy", 64'(o_busy), 64'(1));
    goto(t + 30);
    bus.i_bus_rd_valid = 1'b1; bus.iv_bus_rd_data = 16'h5A5A;
    goto(t + 31);
    bus.i_bus_rd_valid = 1'b0;
    goto(t + 32);
    i_loc_req = 1'b0;
`endif

    // Reset during WAIT_RD with LOC pending; after release the tie goes to SPI.
    t = 92;
    goto(t);
    i_spi_req = 1'b1; i_spi_wr = 1'b0; iv_spi_addr = 16'h0080; iv_spi_wr_data = 16'h0000;
    exp_stb(t + 1, 1'b0, 16'h0080, 16'h0000, 1'b1);
    goto(t + 3);
    i_loc_req = 1'b1; i_loc_wr = 1'b1; iv_loc_addr = 16'h0090; iv_loc_wr_data = 16'h8888;
    goto(t + 4);
    chk("pre_reset_busy", 64'(o_busy), 64'(1));
    reset_reg = 1'b1;
    m_spi_rd = '0;
    m_loc_rd = '0;
    #1;
    rst_chk("rst_mid");
    @(negedge clk_reg);
    rst_chk("rst_hold");
    goto(t + 6);
    i_spi_wr = 1'b1; iv_spi_addr = 16'h0081; iv_spi_wr_data = 16'h7777;
    reset_reg = 1'b0;
    exp_stb(t + 7,  1'b1, 16'h0081, 16'h7777, 1'b1); exp_ack(t + 8,  1'b1, 1'b0);
    exp_stb(t + 10, 1'b1, 16'h0090, 16'h8888, 1'b0); exp_ack(t + 11, 1'b0, 1'b0);
    goto(t + 9);
    i_spi_req = 1'b0;
    goto(t + 12);
    i_loc_req = 1'b0;
    goto(t + 16);

    chk("stb_queue_drained", 64'(stb_q.size()), 64'(0));
    chk("ack_queue_drained", 64'(ack_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
